// File: rtl/grf_sched_pkg.sv
// Shared types and constants for the GRF write-port scheduler.
package grf_sched_pkg;

   localparam int                    REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

   // One buffered long-latency result waiting for a free write slot.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [31:0]           data;
      logic [31:0]           pc;
   } wq_entry_t;

endpackage

// File: rtl/grf_wq_fifo.sv
// Small synchronous FIFO holding long-latency results until the GRF port is free.
// Push is ignored when full and pop is ignored when empty; head is valid whenever !empty.
module grf_wq_fifo
   import grf_sched_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wq_entry_t push_data,
   input  logic      pop,
   output wq_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   wq_entry_t      mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Entry storage; contents need no reset because occupancy gates their use.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/grf_write_sched.sv
// Single GRF write-port scheduler: pipeline writeback has fixed priority, buffered
// long-latency results drain into idle slots, and a busy scoreboard stalls decode on
// hazards against results still in flight.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both high.
// lu_ready and issue_ready depend only on registered state and the presented address,
// never on whether a pop happens in the same cycle.
module grf_write_sched
   import grf_sched_pkg::*;
#(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [31:0]           wb_data,
   input  logic [31:0]           wb_pc,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_addr,
   output logic                  issue_ready,
   input  logic                  lu_valid,
   input  logic [REG_ADDR_W-1:0] lu_addr,
   input  logic [31:0]           lu_data,
   input  logic [31:0]           lu_pc,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] dec_rs,
   input  logic [REG_ADDR_W-1:0] dec_rt,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   output logic                  stall,
   output logic                  grf_we,
   output logic [REG_ADDR_W-1:0] grf_addr,
   output logic [31:0]           grf_data,
   output logic [31:0]           grf_pc
);

   localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   // Bit 0 is never set, so indexing with r0 always reads "not busy".
   logic [31:0]      busy;
   logic [31:0]      busy_next;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_next;

   wq_entry_t q_head;
   wq_entry_t q_in;
   logic      q_full;
   logic      q_empty;
   logic      q_push;
   logic      q_pop;
   logic      wb_hit;
   logic      track;
   logic      retire;

   assign wb_hit      = wb_we && (wb_addr != REG_ZERO);
   assign q_pop       = !reset && !wb_hit && !q_empty;
   assign lu_ready    = !reset && !q_full;
   assign q_push      = lu_valid && lu_ready && (lu_addr != REG_ZERO);
   assign q_in        = '{addr: lu_addr, data: lu_data, pc: lu_pc};
   assign issue_ready = !reset && (outstanding < MAX_CNT) &&
                        !((issue_addr != REG_ZERO) && busy[issue_addr]);
   assign track       = issue_valid && issue_ready && (issue_addr != REG_ZERO);
   assign retire      = q_pop && busy[q_head.addr];
   assign stall       = !reset && (busy[dec_rs] || busy[dec_rt] || busy[dec_rd]);

   grf_wq_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (q_in),
      .pop       (q_pop),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   // Write-port mux: real pipeline writes win, otherwise the queue head drains.
   always_comb begin
      grf_we   = 1'b0;
      grf_addr = REG_ZERO;
      grf_data = '0;
      grf_pc   = '0;
      if (!reset) begin
         if (wb_hit) begin
            grf_we   = 1'b1;
            grf_addr = wb_addr;
            grf_data = wb_data;
            grf_pc   = wb_pc;
         end else if (!q_empty) begin
            grf_we   = 1'b1;
            grf_addr = q_head.addr;
            grf_data = q_head.data;
            grf_pc   = q_head.pc;
         end
      end
   end

   // Scoreboard next state: retire clears, accepted issue sets, counter nets the two.
   always_comb begin
      busy_next        = busy;
      outstanding_next = outstanding;
      if (retire) busy_next[q_head.addr] = 1'b0;
      if (track)  busy_next[issue_addr]  = 1'b1;
      busy_next[0] = 1'b0;
      case ({track, retire})
         2'b10:   outstanding_next = outstanding + 1'b1;
         2'b01:   outstanding_next = outstanding - 1'b1;
         default: outstanding_next = outstanding;
      endcase
   end

   // Scoreboard registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= '0;
         outstanding <= '0;
      end else begin
         busy        <= busy_next;
         outstanding <= outstanding_next;
      end
   end

endmodule

// File: tb/tb_grf_write_sched.sv
// Bench for grf_write_sched: directed scenarios plus a randomized run against a
// queue/array reference model of the write-port rules.
module tb_grf_write_sched;

   localparam int FIFO_DEPTH      = 2;
   localparam int MAX_OUTSTANDING = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready;
   logic        lu_valid;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic [31:0] lu_pc;
   logic        lu_ready;
   logic [4:0]  dec_rs;
   logic [4:0]  dec_rt;
   logic [4:0]  dec_rd;
   logic        stall;
   logic        grf_we;
   logic [4:0]  grf_addr;
   logic [31:0] grf_data;
   logic [31:0] grf_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: pending results in arrival order, busy flags, in-flight count.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] p;
   } m_ent_t;
   m_ent_t mq[$];
   bit     mbusy[32];
   int     mout;

   grf_write_sched #(
      .FIFO_DEPTH      (FIFO_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_pc       (wb_pc),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .lu_valid    (lu_valid),
      .lu_addr     (lu_addr),
      .lu_data     (lu_data),
      .lu_pc       (lu_pc),
      .lu_ready    (lu_ready),
      .dec_rs      (dec_rs),
      .dec_rt      (dec_rt),
      .dec_rd      (dec_rd),
      .stall       (stall),
      .grf_we      (grf_we),
      .grf_addr    (grf_addr),
      .grf_data    (grf_data),
      .grf_pc      (grf_pc)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic idle_inputs();
      wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
      issue_valid = 0; issue_addr = 0;
      lu_valid = 0; lu_addr = 0; lu_data = 0; lu_pc = 0;
      dec_rs = 0; dec_rt = 0; dec_rd = 0;
   endtask

   // Advance the model by the rules for the current inputs, then one clock; returns at negedge.
   task automatic tick();
      int     sz;
      bit     lr;
      bit     ir;
      m_ent_t e;
      if (reset) begin
         mq.delete();
         foreach (mbusy[i]) mbusy[i] = 0;
         mout = 0;
      end else begin
         sz = mq.size();
         lr = (sz < FIFO_DEPTH);
         ir = (mout < MAX_OUTSTANDING) && !(issue_addr != 0 && mbusy[issue_addr]);
         if (!(wb_we && wb_addr != 0) && sz > 0) begin
            e = mq.pop_front();
            if (mbusy[e.a]) begin
               mbusy[e.a] = 0;
               mout--;
            end
         end
         if (issue_valid && ir && issue_addr != 0) begin
            mbusy[issue_addr] = 1;
            mout++;
         end
         if (lu_valid && lr && lu_addr != 0) begin
            e.a = lu_addr; e.d = lu_data; e.p = lu_pc;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      tick();
      wb_we = 1; wb_addr = 8; wb_data = 32'h55; issue_valid = 1; issue_addr = 3;
      #1;
      n_tests++;
      if (grf_we !== 1'b0 || lu_ready !== 1'b0 || issue_ready !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b lu_ready=%b issue_ready=%b stall=%b expected all 0",
                  grf_we, lu_ready, issue_ready, stall);
      end
      tick();
      reset = 0;
      idle_inputs();
      #1;
      n_tests++;
      if (grf_we !== 1'b0 || lu_ready !== 1'b1 || issue_ready !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got we=%b lu_ready=%b issue_ready=%b stall=%b expected 0 1 1 0",
                  grf_we, lu_ready, issue_ready, stall);
      end
      tick();
   endtask

   task automatic test_wb_direct();
      wb_we = 1; wb_addr = 8; wb_data = 32'h1234; wb_pc = 32'h400;
      #1;
      n_tests++;
      if (grf_we !== 1'b1 || grf_addr !== 5'd8 || grf_data !== 32'h1234 || grf_pc !== 32'h400) begin
         n_fail++;
         $display("FAIL wb_direct: got we=%b addr=%0d data=%h pc=%h expected 1 8 1234 400",
                  grf_we, grf_addr, grf_data, grf_pc);
      end
      wb_we = 0;
      #1;
      n_tests++;
      if (grf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL wb_release: got we=%b expected 0", grf_we);
      end
      tick();
   endtask

   task automatic test_stall_drain();
      issue_valid = 1; issue_addr = 5;
      #1;
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue5_accept: got %b expected 1", issue_ready);
      end
      tick();
      issue_valid = 0; dec_rs = 5;
      lu_valid = 1; lu_addr = 5; lu_data = 32'hABCD; lu_pc = 32'h100;
      wb_we = 1; wb_addr = 9; wb_data = 32'h9; wb_pc = 32'h200;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (stall !== 1'b1 || grf_we !== 1'b1 || grf_addr !== 5'd9) begin
            n_fail++;
            $display("FAIL stall_hold cycle %0d: got stall=%b we=%b addr=%0d expected 1 1 9",
                     c, stall, grf_we, grf_addr);
         end
         tick();
         lu_valid = 0;
      end
      wb_we = 0;
      #1;
      n_tests++;
      if (grf_we !== 1'b1 || grf_addr !== 5'd5 || grf_data !== 32'hABCD || grf_pc !== 32'h100 || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_write: got we=%b addr=%0d data=%h pc=%h stall=%b expected 1 5 abcd 100 1",
                  grf_we, grf_addr, grf_data, grf_pc, stall);
      end
      tick();
      #1;
      n_tests++;
      if (stall !== 1'b0 || grf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_drop: got stall=%b we=%b expected 0 0", stall, grf_we);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_full_queue();
      wb_we = 1; wb_addr = 9; wb_data = 32'h99;
      lu_valid = 1;
      for (int k = 0; k < 3; k++) begin
         lu_addr = 5'(10 + k); lu_data = 32'hA0 + k; lu_pc = 32'h300 + k;
         #1;
         n_tests++;
         if (lu_ready !== (k < 2)) begin
            n_fail++;
            $display("FAIL fill_lu_ready %0d: got %b expected %b", k, lu_ready, (k < 2));
         end
         tick();
      end
      wb_we = 0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) lu_valid = 0;
         #1;
         n_tests++;
         if (grf_we !== 1'b1 || grf_addr !== 5'(10 + k) || grf_data !== 32'hA0 + k || lu_ready !== (k > 0)) begin
            n_fail++;
            $display("FAIL drain %0d: got we=%b addr=%0d data=%h lu_ready=%b expected 1 %0d %h %b",
                     k, grf_we, grf_addr, grf_data, lu_ready, 10 + k, 32'hA0 + k, (k > 0));
         end
         tick();
      end
      #1;
      n_tests++;
      if (grf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got we=%b expected 0", grf_we);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_outstanding();
      issue_valid = 1;
      for (int r = 1; r <= 4; r++) begin
         issue_addr = 5'(r);
         #1;
         n_tests++;
         if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_fill r%0d: got %b expected 1", r, issue_ready);
         end
         tick();
      end
      issue_addr = 6;
      lu_valid = 1; lu_addr = 1; lu_data = 32'h11; lu_pc = 32'h500;
      #1;
      n_tests++;
      if (issue_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL issue_limit: got %b expected 0", issue_ready);
      end
      tick();
      lu_valid = 0;
      #1;
      n_tests++;
      if (issue_ready !== 1'b0 || grf_we !== 1'b1 || grf_addr !== 5'd1) begin
         n_fail++;
         $display("FAIL issue_limit_retire: got ready=%b we=%b addr=%0d expected 0 1 1",
                  issue_ready, grf_we, grf_addr);
      end
      tick();
      issue_addr = 2;
      #1;
      n_tests++;
      if (issue_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL issue_busy_reg: got %b expected 0", issue_ready);
      end
      issue_addr = 6;
      #1;
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_after_retire: got %b expected 1", issue_ready);
      end
      tick();
      issue_valid = 0;
      lu_valid = 1;
      for (int k = 0; k < 4; k++) begin
         lu_addr = (k == 3) ? 5'd6 : 5'(k + 2);
         lu_data = 32'h60 + k;
         tick();
      end
      lu_valid = 0;
      tick();
      tick();
      dec_rs = 2; dec_rt = 6; dec_rd = 4; issue_addr = 2;
      #1;
      n_tests++;
      if (stall !== 1'b0 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL all_retired: got stall=%b ready=%b expected 0 1", stall, issue_ready);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_zero_addr();
      wb_we = 1; wb_addr = 9;
      lu_valid = 1; lu_addr = 13; lu_data = 32'hD; lu_pc = 32'h700;
      tick();
      lu_valid = 0;
      wb_addr = 0; wb_data = 32'hFF;
      #1;
      n_tests++;
      if (grf_we !== 1'b1 || grf_addr !== 5'd13 || grf_data !== 32'hD) begin
         n_fail++;
         $display("FAIL wb_r0_frees_slot: got we=%b addr=%0d data=%h expected 1 13 d",
                  grf_we, grf_addr, grf_data);
      end
      tick();
      wb_we = 0;
      lu_valid = 1; lu_addr = 0; lu_data = 32'hEE;
      issue_valid = 1; issue_addr = 0;
      #1;
      n_tests++;
      if (lu_ready !== 1'b1 || grf_we !== 1'b0 || issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r0_result_accept: got lu_ready=%b we=%b issue_ready=%b expected 1 0 1",
                  lu_ready, grf_we, issue_ready);
      end
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (grf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_result_dropped: got we=%b expected 0", grf_we);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      issue_valid = 1;
      for (int r = 20; r <= 22; r++) begin
         issue_addr = 5'(r);
         tick();
      end
      issue_valid = 0;
      wb_we = 1; wb_addr = 9;
      lu_valid = 1;
      for (int r = 23; r <= 24; r++) begin
         lu_addr = 5'(r); lu_data = 32'(r);
         tick();
      end
      lu_valid = 0; dec_rs = 20;
      #1;
      n_tests++;
      if (lu_ready !== 1'b0 || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_state: got lu_ready=%b stall=%b expected 0 1", lu_ready, stall);
      end
      reset = 1;
      tick();
      #1;
      n_tests++;
      if (grf_we !== 1'b0 || lu_ready !== 1'b0 || issue_ready !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got we=%b lu_ready=%b issue_ready=%b stall=%b expected all 0",
                  grf_we, lu_ready, issue_ready, stall);
      end
      tick();
      reset = 0;
      idle_inputs();
      dec_rs = 20; dec_rt = 21; dec_rd = 22; issue_addr = 20;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if (grf_we !== 1'b0 || stall !== 1'b0 || issue_ready !== 1'b1 || lu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset %0d: got we=%b stall=%b issue_ready=%b lu_ready=%b expected 0 0 1 1",
                     c, grf_we, stall, issue_ready, lu_ready);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_random();
      bit          e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [31:0] e_pc;
      bit          e_lr;
      bit          e_ir;
      bit          e_stall;
      for (int c = 0; c < 500; c++) begin
         wb_we       = ($urandom_range(0, 99) < 40);
         wb_addr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wb_data     = $urandom;
         wb_pc       = $urandom;
         issue_valid = ($urandom_range(0, 99) < 30);
         issue_addr  = 5'($urandom_range(0, 7));
         lu_valid    = ($urandom_range(0, 99) < 45);
         lu_addr     = 5'($urandom_range(0, 7));
         lu_data     = $urandom;
         lu_pc       = $urandom;
         dec_rs      = 5'($urandom_range(0, 7));
         dec_rt      = 5'($urandom_range(0, 7));
         dec_rd      = 5'($urandom_range(0, 7));
         e_we = 0; e_addr = 0; e_data = 0; e_pc = 0;
         if (wb_we && wb_addr != 0) begin
            e_we = 1; e_addr = wb_addr; e_data = wb_data; e_pc = wb_pc;
         end else if (mq.size() > 0) begin
            e_we = 1; e_addr = mq[0].a; e_data = mq[0].d; e_pc = mq[0].p;
         end
         e_lr    = (mq.size() < FIFO_DEPTH);
         e_ir    = (mout < MAX_OUTSTANDING) && !(issue_addr != 0 && mbusy[issue_addr]);
         e_stall = (dec_rs != 0 && mbusy[dec_rs]) || (dec_rt != 0 && mbusy[dec_rt]) ||
                   (dec_rd != 0 && mbusy[dec_rd]);
         #1;
         n_tests++;
         if (grf_we !== e_we || (e_we && (grf_addr !== e_addr || grf_data !== e_data || grf_pc !== e_pc))) begin
            n_fail++;
            $display("FAIL rand_port c%0d: got we=%b addr=%0d data=%h pc=%h expected %b %0d %h %h",
                     c, grf_we, grf_addr, grf_data, grf_pc, e_we, e_addr, e_data, e_pc);
         end
         n_tests++;
         if (lu_ready !== e_lr || issue_ready !== e_ir || stall !== e_stall) begin
            n_fail++;
            $display("FAIL rand_ctrl c%0d: got lu_ready=%b issue_ready=%b stall=%b expected %b %b %b",
                     c, lu_ready, issue_ready, stall, e_lr, e_ir, e_stall);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      mout = 0;
      @(negedge clk);
      test_reset();
      test_wb_direct();
      test_stall_drain();
      test_full_queue();
      test_outstanding();
      test_zero_addr();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_write_sched.md
# grf_write_sched

Scheduler for the register file's single write port. Shares it between the in-order pipeline writeback (fixed priority, never stalled) and a long-latency unit (MDU/multi-cycle load) whose results are buffered in a small queue and drained into idle write slots. Keeps a per-register busy scoreboard for destinations of in-flight long-latency ops and raises a decode stall on any hazard against them. Sits between the W stage, the long-latency unit, decode, and the GRF write port.

## Interface
- FIFO_DEPTH, 2, entries in the long-latency result queue (power of two, ≥2)
- MAX_OUTSTANDING, 4, maximum tracked in-flight long-latency destinations
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_we  in  1  pipeline writeback request
- wb_addr  in  5  pipeline writeback register
- wb_data  in  32  pipeline writeback value
- wb_pc  in  32  PC of the writing instruction
- issue_valid  in  1  long-latency op issued with a destination
- issue_addr  in  5  its destination register
- issue_ready  out  1  issue accepted this cycle
- lu_valid  in  1  long-latency result valid
- lu_addr  in  5  result register
- lu_data  in  32  result value
- lu_pc  in  32  result PC
- lu_ready  out  1  queue can accept a result
- dec_rs, dec_rt, dec_rd  in  5 each  decode-stage source and destination registers
- stall  out  1  decode must hold
- grf_we  out  1  GRF write enable
- grf_addr  out  5  GRF write address
- grf_data  out  32  GRF write data
- grf_pc  out  32  GRF write PC

## Operation
- Write-port mux, combinational:
  - If wb_we=1 and wb_addr≠0, the port carries wb_*.
  - Otherwise, if the queue is non-empty, it carries the queue head with grf_we=1, and the head pops at the clock edge.
  - Otherwise grf_we=0.
  - wb_we with wb_addr=0 counts as no write, so the slot is free for the queue.
- Queue:
  - A FIFO of {addr, data, pc}. Enqueue on lu_valid && lu_ready.
  - Results with lu_addr=0 are handshaken and discarded, never enqueued.
  - lu_ready = !full. It depends only on registered state, not on the same-cycle pop.
- Scoreboard:
  - 31-bit busy vector (index 0 absent) plus outstanding counter 0..MAX_OUTSTANDING.
  - issue_ready = !reset && outstanding<MAX_OUTSTANDING && !(issue_addr≠0 && busy[issue_addr]).
  - Accepted issue with addr≠0: set busy and increment outstanding. Issue with addr 0: accepted but not tracked.
  - A queue pop to a busy register clears that bit and decrements outstanding. A pop to a non-busy register still writes; the scoreboard is unchanged.
  - Pipeline writes never touch the scoreboard.
  - Simultaneous issue accept and pop: the counter nets to unchanged. A clear and a set of the same register cannot coincide, because issue to a busy register is refused.
- stall = any of dec_rs/dec_rt/dec_rd nonzero with its busy bit set. This covers RAW and WAW against pending results.

## Timing
- Result accepted at edge N reaches the GRF at the earliest at edge N+1. It is delayed one cycle for each cycle the pipeline holds the port.
- A busy bit clears at the edge where the GRF write occurs. stall drops the following cycle, when the GRF read returns the new value. No bypass path exists.
- Issue at edge N: busy visible, and stall can assert, from cycle N+1.
- Full queue: lu_ready=0 even if a pop happens that cycle. It rises the cycle after the pop.
- Reset, including mid-operation: queue empty, busy=0, outstanding=0, grf_we=0, lu_ready=0, issue_ready=0, stall=0. Queued results are dropped.
- The wb_* path bypasses the queue entirely. Its latency is zero, so grf_we follows wb_we in the same cycle.

## Structure
- Package grf_sched_pkg holds:
  - REG_ADDR_W=5, REG_ZERO=5'd0
  - the wq_entry_t struct {addr, data, pc}
- Sub-module grf_wq_fifo: a parameterised synchronous FIFO with push/pop, full/empty, and head data. The arbiter logic and scoreboard stay in the top module.

## Test plan
- Idle queue, wb_we=1 addr 8 data 0x1234 → grf_we=1, grf_addr=8, grf_data=0x1234 in the same cycle.
- Issue addr 5, then result addr 5 data 0xABCD while wb writes addr 9 for 3 consecutive cycles → stall=1 for dec_rs=5 throughout; the result is written on the first cycle with no wb; stall=0 the next cycle.
- Fill the queue (2 results, wb held busy) → lu_ready=0. Release wb → one pop per cycle; lu_ready rises the cycle after the first pop.
- 4 issues to regs 1–4 → issue_ready=0 for the 5th issue (reg 6) until one result retires. A second issue to busy reg 2 is refused even when outstanding<4.
- wb_we=1 with wb_addr=0 while the queue is non-empty → the queue head is written that cycle. Result with lu_addr=0 → accepted, no GRF write.
- Reset asserted with 2 queued results and 3 busy registers → next cycle all outputs 0. After release no stale writes occur and issue_ready=1.
